// File: rtl/nbody_bus_slave.sv
// nbody_bus_slave: host bus register file and two-half double staging for the n-body core.
module nbody_bus_slave #(
  parameter int BODY_ADDR_WIDTH = 9,
  parameter int MAX_BODIES      = 512
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       chipselect,
  input  logic                       write,
  input  logic                       read,
  input  logic [15:0]                addr,
  input  logic [63:0]                writedata,
  output logic [63:0]                readdata,
  output logic                       mem_we,
  output logic [2:0]                 mem_field,
  output logic [BODY_ADDR_WIDTH-1:0] mem_idx,
  output logic [63:0]                mem_wdata,
  output logic                       go,
  output logic                       go_pulse,
  output logic                       read_mode,
  output logic [15:0]                n_bodies,
  output logic [31:0]                gap,
  input  logic                       done,
  output logic [BODY_ADDR_WIDTH-1:0] res_idx,
  output logic                       res_sel,
  input  logic [63:0]                res_rdata
);
  logic [6:0] sel;
  logic [BODY_ADDR_WIDTH-1:0] idx;
  logic wr, rd, busy, data_sel, lo_wr, up_wr, up_ok, err_set;
  logic [2:0] fld;
  logic go_q, go_d, go_pulse_q, read_mode_q, read_mode_d, err_q, err_d, mem_we_q;
  logic [15:0] n_bodies_q, n_bodies_d;
  logic [31:0] gap_q, gap_d;
  logic [4:0] vld_q, vld_d;
  logic [4:0][31:0] lo_q, lo_d;
  logic [4:0][BODY_ADDR_WIDTH-1:0] sidx_q, sidx_d;
  logic [63:0] rdata_q, rdata_d, mem_wdata_q;
  logic [2:0] mem_field_q;
  logic [BODY_ADDR_WIDTH-1:0] mem_idx_q;
  logic unused_hi;

  assign sel = 7'(addr[15:BODY_ADDR_WIDTH]);
  assign idx = addr[BODY_ADDR_WIDTH-1:0];
  assign wr = chipselect & write;
  assign rd = chipselect & read & ~write;
  assign busy = go_q & ~done;
  // data selects come in lower/upper pairs: sel[6:1] names the field, sel[0] the half
  assign fld = sel[6:1] == 6'h02 ? 3'd0 : sel[6:1] == 6'h03 ? 3'd1 :
               sel[6:1] == 6'h04 ? 3'd2 : sel[6:1] == 6'h08 ? 3'd3 : 3'd4;
  assign data_sel = sel[6:1] == 6'h02 || sel[6:1] == 6'h03 || sel[6:1] == 6'h04 ||
                    sel[6:1] == 6'h08 || sel[6:1] == 6'h09;
  assign lo_wr = wr & data_sel & ~sel[0] & ~busy;
  assign up_wr = wr & data_sel & sel[0] & ~busy;
  assign up_ok = up_wr & vld_q[fld] & (sidx_q[fld] == idx);
  assign err_set = (wr & data_sel & busy) | (up_wr & ~up_ok);
  assign unused_hi = ^writedata[63:32];

  always_comb begin
    go_d = wr && sel == 7'h00 ? writedata[0] : go_q;
    read_mode_d = wr && sel == 7'h01 ? writedata[0] : read_mode_q;
    n_bodies_d = !(wr && sel == 7'h02) ? n_bodies_q :
                 writedata[15:0] > 16'(MAX_BODIES) ? 16'(MAX_BODIES) : writedata[15:0];
    gap_d = wr && sel == 7'h03 ? writedata[31:0] : gap_q;
    err_d = err_set | (err_q & ~(rd && sel == 7'h40));
    vld_d = vld_q;
    lo_d = lo_q;
    sidx_d = sidx_q;
    if (lo_wr) begin
      vld_d[fld] = 1'b1;
      lo_d[fld] = writedata[31:0];
      sidx_d[fld] = idx;
    end
    if (up_ok) vld_d[fld] = 1'b0;
    rdata_d = !rd ? rdata_q :
              sel == 7'h40 ? {62'b0, err_q, done} :
              sel == 7'h41 || sel == 7'h43 ? {32'b0, res_rdata[31:0]} :
              sel == 7'h42 || sel == 7'h44 ? {32'b0, res_rdata[63:32]} : 64'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      go_q <= 1'b0;
      go_pulse_q <= 1'b0;
      read_mode_q <= 1'b0;
      n_bodies_q <= '0;
      gap_q <= '0;
      err_q <= 1'b0;
      vld_q <= '0;
      lo_q <= '0;
      sidx_q <= '0;
      rdata_q <= '0;
      mem_we_q <= 1'b0;
      mem_field_q <= '0;
      mem_idx_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      go_q <= go_d;
      go_pulse_q <= go_d & ~go_q;
      read_mode_q <= read_mode_d;
      n_bodies_q <= n_bodies_d;
      gap_q <= gap_d;
      err_q <= err_d;
      vld_q <= vld_d;
      lo_q <= lo_d;
      sidx_q <= sidx_d;
      rdata_q <= rdata_d;
      mem_we_q <= up_ok;
      if (up_ok) begin
        mem_field_q <= fld;
        mem_idx_q <= idx;
        mem_wdata_q <= {writedata[31:0], lo_q[fld]};
      end
    end
  end

  assign readdata = rdata_q;
  assign mem_we = mem_we_q;
  assign mem_field = mem_field_q;
  assign mem_idx = mem_idx_q;
  assign mem_wdata = mem_wdata_q;
  assign go = go_q;
  assign go_pulse = go_pulse_q;
  assign read_mode = read_mode_q;
  assign n_bodies = n_bodies_q;
  assign gap = gap_q;
  assign res_idx = idx;
  assign res_sel = sel == 7'h43 || sel == 7'h44;
endmodule
